// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: issues word fetches under a credit limit, queues in-order
// responses and drives the IF/ID latch; a redirect flushes the queue and drops stale returns.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        ifid_valid,
    output logic [31:0] ifid_ir,
    output logic [31:0] ifid_pc4
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(QDEPTH);
    localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE      = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ZERO     = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE      = PW'(1'b1);

    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   q_ir_q  [QDEPTH];
    logic [31:0]   q_pc4_q [QDEPTH];
    logic          ifid_valid_q, ifid_valid_d;
    logic [31:0]   ifid_ir_q, ifid_ir_d;
    logic [31:0]   ifid_pc4_q, ifid_pc4_d;

    logic [CW:0]   credits_s;
    logic          req_s;
    logic          hs_s;
    logic          rsp_ok_s;
    logic          push_s;
    logic          load_s;
    logic          pop_s;
    logic [31:0]   target_s;
    logic [1:0]    unused_rpc_lsb_s;

    assign unused_rpc_lsb_s = redirect_pc[1:0];

    // Handshake qualifiers; a queue entry being popped still holds its credit this cycle.
    always_comb begin
        credits_s = {1'b0, outstanding_q} + {1'b0, count_q};
        req_s     = !reset && (credits_s < CREDIT_LIMIT);
        hs_s      = req_s && imem_ready;
        rsp_ok_s  = imem_rsp_valid && (outstanding_q != CNT_ZERO);
        push_s    = rsp_ok_s && (drop_q == CNT_ZERO) && !redirect;
        load_s    = !stall || !ifid_valid_q;
        pop_s     = load_s && (count_q != CNT_ZERO) && !redirect;
        target_s  = word_align(redirect_pc);
    end

    // Fetch PC, in-flight count and the number of stale responses still to discard.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(hs_s) - CW'(rsp_ok_s);
        if (redirect) begin
            fetch_pc_d = target_s;
            // Everything still in flight after this cycle, including a fetch accepted now, is stale.
            drop_d     = outstanding_d;
        end else begin
            if (hs_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_ok_s && (drop_q != CNT_ZERO)) begin
                drop_d = drop_q - CNT_ONE;
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // Response queue pointers; rsp_pc tracks the fetch address of the next kept response.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rsp_pc_d = rsp_pc_q;
        if (redirect) begin
            head_d   = PTR_ZERO;
            tail_d   = PTR_ZERO;
            count_d  = CNT_ZERO;
            rsp_pc_d = target_s;
        end else begin
            if (push_s) begin
                tail_d   = tail_q + PTR_ONE;
                rsp_pc_d = rsp_pc_q + 32'd4;
            end else begin
                tail_d   = tail_q;
                rsp_pc_d = rsp_pc_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // IF/ID latch: load from the queue head when ID can accept, clear on redirect.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_ir_d    = ifid_ir_q;
        ifid_pc4_d   = ifid_pc4_q;
        if (redirect) begin
            ifid_valid_d = 1'b0;
        end else if (load_s) begin
            ifid_valid_d = (count_q != CNT_ZERO);
            if (pop_s) begin
                ifid_ir_d  = q_ir_q[head_q];
                ifid_pc4_d = q_pc4_q[head_q];
            end else begin
                ifid_ir_d  = ifid_ir_q;
                ifid_pc4_d = ifid_pc4_q;
            end
        end else begin
            ifid_valid_d = ifid_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= CNT_ZERO;
            drop_q        <= CNT_ZERO;
            count_q       <= CNT_ZERO;
            head_q        <= PTR_ZERO;
            tail_q        <= PTR_ZERO;
            ifid_valid_q  <= 1'b0;
            ifid_ir_q     <= 32'h0000_0000;
            ifid_pc4_q    <= 32'h0000_0000;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_ir_q     <= ifid_ir_d;
            ifid_pc4_q    <= ifid_pc4_d;
        end
    end

    // Queue storage; contents are only meaningful between tail and head, so no reset.
    always_ff @(posedge clock) begin
        if (!reset && push_s) begin
            q_ir_q[tail_q]  <= imem_rsp_data;
            q_pc4_q[tail_q] <= rsp_pc_q + 32'd4;
        end else begin
            q_ir_q[tail_q]  <= q_ir_q[tail_q];
            q_pc4_q[tail_q] <= q_pc4_q[tail_q];
        end
    end

    assign imem_req   = req_s;
    assign imem_addr  = fetch_pc_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_ir    = ifid_ir_q;
    assign ifid_pc4   = ifid_pc4_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: in-order memory model plus a queue-based reference of the
// fetch stage, compared every cycle, with directed scenarios followed by random traffic.
module tb_mips_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        ifid_valid;
    logic [31:0] ifid_ir;
    logic [31:0] ifid_pc4;

    always #5 clock = ~clock;

    mips_fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .ifid_valid(ifid_valid),
        .ifid_ir(ifid_ir), .ifid_pc4(ifid_pc4)
    );

    typedef struct { logic [31:0] addr; bit stale; } fetch_t;
    typedef struct { logic [31:0] ir; logic [31:0] pc4; } inst_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    fetch_t      pend[$];   // accepted fetches not yet returned, oldest first
    inst_t       bufq[$];   // returned, kept instructions waiting for IF/ID
    mreq_t       memq[$];   // memory-side view of accepted requests
    logic [31:0] m_pc = RESET_PC;
    bit          m_ifv = 1'b0;
    logic [31:0] m_ir = 32'h0;
    logic [31:0] m_pc4 = 32'h0;
    int cyc = 0, vectors = 0, miscompares = 0;
    int mem_lat = 1, rsp_pct = 100, last_due = 0;
    bit mem_hash = 1'b0;
    bit found;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return mem_hash ? ((a ^ 32'hA5C3_0F96) + {a[7:0], 24'h000000}) : a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, compare against the reference, advance at posedge.
    task automatic tick(input bit rst, input bit stl, input bit red, input logic [31:0] rpc, input bit rdy);
        bit          req, hs, rv;
        logic [31:0] rd, addr_seen;
        fetch_t      f;
        inst_t       head;
        bit          have_head;
        int          due;
        @(negedge clock);
        reset = rst; stall = stl; redirect = red; redirect_pc = rpc; imem_ready = rdy;
        rv = 1'b0;
        rd = $urandom();
        if (memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
            rv = 1'b1;
            rd = mem_data(memq[0].addr);
        end
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        #1;
        req = !rst && ((pend.size() + bufq.size()) < QDEPTH);
        check("imem_req", imem_req, req);
        check("imem_addr", imem_addr, m_pc);
        check("ifid_valid", ifid_valid, m_ifv);
        check("ifid_ir", ifid_ir, m_ir);
        check("ifid_pc4", ifid_pc4, m_pc4);
        addr_seen = imem_addr;
        @(posedge clock);
        hs = req && rdy;
        if (rst) begin
            memq.delete();
            last_due = 0;
            pend.delete();
            bufq.delete();
            m_pc = RESET_PC; m_ifv = 1'b0; m_ir = 32'h0; m_pc4 = 32'h0;
        end else begin
            if (rv) void'(memq.pop_front());
            if (hs) begin
                due = (cyc + mem_lat > last_due) ? cyc + mem_lat : last_due;
                memq.push_back(mreq_t'{addr: addr_seen, due: due});
                last_due = due;
            end
            have_head = (bufq.size() > 0);
            if (have_head) head = bufq[0];
            if (rv) begin
                if (pend.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_no_outstanding at cycle %0d: got response, expected none", cyc);
                end else begin
                    f = pend.pop_front();
                    if (!f.stale && !red) bufq.push_back(inst_t'{ir: rd, pc4: f.addr + 32'd4});
                end
            end
            if (red) begin
                bufq.delete();
                m_ifv = 1'b0;
            end else if (!stl || !m_ifv) begin
                if (have_head) begin
                    void'(bufq.pop_front());
                    m_ir = head.ir; m_pc4 = head.pc4; m_ifv = 1'b1;
                end else begin
                    m_ifv = 1'b0;
                end
            end
            if (hs) begin
                pend.push_back(fetch_t'{addr: m_pc, stale: red});
                m_pc = m_pc + 32'd4;
            end
            if (red) begin
                foreach (pend[i]) pend[i].stale = 1'b1;
                m_pc = {rpc[31:2], 2'b00};
            end
            if (bufq.size() > QDEPTH) begin
                miscompares++;
                $display("FAIL queue_overflow at cycle %0d: got %0d entries, limit %0d", cyc, bufq.size(), QDEPTH);
            end
        end
        cyc++;
    endtask

    initial begin
        // Reset, then streaming with 1-cycle memory returning mem[a] = a.
        repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        check("rst_req", imem_req, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_ifv", ifid_valid, 32'd0);
        check("rst_ir", ifid_ir, 32'd0);
        check("rst_pc4", ifid_pc4, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1; check("lat_not_yet", ifid_valid, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1; check("first_ifv", ifid_valid, 32'd1);
        check("first_ir", ifid_ir, 32'h0);
        check("first_pc4", ifid_pc4, 32'h4);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1; check("second_ir", ifid_ir, 32'h4);
        check("second_pc4", ifid_pc4, 32'h8);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1; check("stream_ir", ifid_ir, 32'h10);

        // Stall for 3 cycles: IF/ID holds and requests stop once credits run out.
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        #1; check("stall_hold0", ifid_ir, 32'h10);
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        #1; check("stall_req_off", imem_req, 32'd0);
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        #1; check("stall_hold2", ifid_ir, 32'h10);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1; check("resume_ir", ifid_ir, 32'h14);
        check("resume_pc4", ifid_pc4, 32'h18);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Memory not ready for 4 cycles.
        repeat (4) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect to 0x43 with two fetches outstanding, 3-cycle memory.
        mem_lat = 3;
        repeat (2) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 32'h0000_0043, 1'b0);
        #1; check("redir_addr", imem_addr, 32'h40);
        check("redir_ifv", ifid_valid, 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            #1;
            if (ifid_valid) found = 1'b1;
        end
        check("redir_found", found, 32'd1);
        check("redir_ir", ifid_ir, 32'h40);
        check("redir_pc4", ifid_pc4, 32'h44);

        // Redirect and stall together while IF/ID is valid.
        repeat (2) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1; check("rs_pre_valid", ifid_valid, 32'd1);
        tick(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1);
        #1; check("rs_ifv", ifid_valid, 32'd0);
        check("rs_addr", imem_addr, 32'h100);
        repeat (8) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset with two fetches outstanding and two queued.
        mem_lat = 2;
        repeat (2) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("mid_credits", pend.size() + bufq.size(), 32'd4);
        tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        #1; check("mid_rst_req", imem_req, 32'd0);
        check("mid_rst_addr", imem_addr, RESET_PC);
        check("mid_rst_ifv", ifid_valid, 32'd0);
        check("mid_rst_ir", ifid_ir, 32'd0);
        check("mid_rst_pc4", ifid_pc4, 32'd0);
        repeat (6) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Randomised traffic.
        mem_hash = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            mem_lat = 1 + $urandom_range(3);
            rsp_pct = (k < 2000) ? 70 : 100;
            tick(($urandom_range(299) == 0),
                 ($urandom_range(99) < ((k < 2000) ? 30 : 10)),
                 ($urandom_range(99) < 5),
                 $urandom(),
                 ($urandom_range(99) < 75));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
